// File: rtl/spi_slave_piso.sv
// SPI slave transmit engine: one-word holding buffer, SCLK/CSn synchronisers, MISO serialiser.
// Optional `SPI_SLAVE_PISO_REPEAT_EN resends the last loaded word on underrun instead of all ones.
//
// state | meaning
// IDLE  | deselected, MISO not driven, bit counter cleared
// LOAD  | one clk after CSn fall: buffer (or fill word) moves into the shift register
// SHIFT | selected, bits launched/sampled on SCLK edges, reload at every word boundary
module spi_slave_piso #(
    parameter int WordLen    = 8,
    parameter int SyncStages = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               SCLK,
    input  logic               CSn,
    input  logic               CPOL,
    input  logic               CPHA,
    input  logic               Endiannes,
    input  logic [WordLen-1:0] TxData,
    input  logic               TxValid,
    output logic               TxReady,
    output logic               MISO,
    output logic               MISOOE,
    output logic               WordDone,
    output logic               Underrun
);

    localparam int CntW = $clog2(WordLen + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t               state, state_nxt;
    logic [SyncStages-1:0] sclk_sync, csn_sync;
    logic                 sclk_prev, csn_prev;
    logic                 sclk_s, csn_s;
    logic                 lead_edge, trail_edge, launch_edge, sample_edge;
    logic                 csn_fall, csn_rise;
    logic                 load_word, word_end;
    logic [WordLen-1:0]   shreg, buf_data, fill_word, load_src, load_shifted;
    logic                 buf_full, miso_q, hold_launch, word_done_q, underrun_q;
    logic [CntW-1:0]      bit_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            csn_sync  <= '0;
            sclk_prev <= 1'b0;
            csn_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SyncStages-2:0], SCLK};
            csn_sync  <= {csn_sync[SyncStages-2:0], CSn};
            sclk_prev <= sclk_sync[SyncStages-1];
            csn_prev  <= csn_sync[SyncStages-1];
        end
    end

    // CSn chain resets low so a select already held through reset is not seen as a fresh fall.
    assign sclk_s      = sclk_sync[SyncStages-1];
    assign csn_s       = csn_sync[SyncStages-1];
    assign lead_edge   = CPOL ? (~sclk_s & sclk_prev) : (sclk_s & ~sclk_prev);
    assign trail_edge  = CPOL ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);
    assign launch_edge = CPHA ? lead_edge : trail_edge;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign csn_fall    = ~csn_s & csn_prev;
    assign csn_rise    = csn_s & ~csn_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        word_end  = 1'b0;
        case (state)
            IDLE: if (csn_fall) state_nxt = LOAD;
            LOAD: begin
                load_word = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (sample_edge && bit_cnt == CntW'(WordLen - 1)) begin
                    word_end  = 1'b1;
                    load_word = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (csn_rise) begin
            state_nxt = IDLE;
            load_word = 1'b0;
            word_end  = 1'b0;
        end
    end

`ifdef SPI_SLAVE_PISO_REPEAT_EN
    logic [WordLen-1:0] last_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                      last_word <= '1;
        else if (load_word && buf_full) last_word <= buf_data;
    end

    assign fill_word = last_word;
`else
    assign fill_word = '1;
`endif

    assign load_src     = buf_full ? buf_data : fill_word;
    assign load_shifted = Endiannes ? {load_src[WordLen-2:0], 1'b0} : {1'b0, load_src[WordLen-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg       <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            miso_q      <= 1'b0;
            hold_launch <= 1'b0;
            bit_cnt     <= '0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            word_done_q <= word_end;
            underrun_q  <= load_word & ~buf_full;
            if (load_word) buf_full <= 1'b0;
            if (TxValid && !buf_full) begin
                buf_data <= TxData;
                buf_full <= 1'b1;
            end
            if (state == IDLE) begin
                bit_cnt     <= '0;
                hold_launch <= 1'b0;
                miso_q      <= 1'b0;
            end else if (load_word) begin
                bit_cnt <= '0;
                if (!CPHA) begin
                    // First bit goes out now; on a reload the trailing edge that follows is already covered.
                    miso_q      <= Endiannes ? load_src[WordLen-1] : load_src[0];
                    shreg       <= load_shifted;
                    hold_launch <= (state == SHIFT);
                end else begin
                    shreg       <= load_src;
                    hold_launch <= 1'b0;
                end
            end else if (state == SHIFT) begin
                if (sample_edge) bit_cnt <= bit_cnt + CntW'(1);
                if (launch_edge) begin
                    if (hold_launch) begin
                        hold_launch <= 1'b0;
                    end else begin
                        miso_q <= Endiannes ? shreg[WordLen-1] : shreg[0];
                        shreg  <= Endiannes ? {shreg[WordLen-2:0], 1'b0} : {1'b0, shreg[WordLen-1:1]};
                    end
                end
            end
        end
    end

    assign TxReady  = ~buf_full;
    assign MISO     = miso_q;
    assign MISOOE   = (state != IDLE);
    assign WordDone = word_done_q;
    assign Underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_piso.sv
// Bench for spi_slave_piso: acts as SPI master, scoreboards MISO bits and WordDone/Underrun pulses
// against a word-level model of the holding buffer (honours SPI_SLAVE_PISO_REPEAT_EN).
module tb_spi_slave_piso;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int H  = 8;

    logic         clk, rstn, SCLK, CSn, CPOL, CPHA, Endiannes, TxValid;
    logic [W-1:0] TxData;
    logic         TxReady, MISO, MISOOE, WordDone, Underrun;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mbuf[$];
    logic         exp_bits[$];
    logic [W-1:0] cur_word, last_word;
    int           exp_wd, exp_ur;
    logic         in_xfer;
    logic         mon_lead, mon_exp;

    spi_slave_piso #(.WordLen(W), .SyncStages(SS)) dut (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .CSn(CSn), .CPOL(CPOL), .CPHA(CPHA),
        .Endiannes(Endiannes), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .MISO(MISO), .MISOOE(MISOOE), .WordDone(WordDone), .Underrun(Underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        mbuf.delete();
        exp_bits.delete();
        exp_wd    = 0;
        exp_ur    = 0;
        last_word = '1;
    endfunction

    // A word starts at every select and at every completed word; an empty buffer means fill + underrun.
    function automatic void start_word();
        if (mbuf.size() > 0) begin
            cur_word  = mbuf.pop_front();
            last_word = cur_word;
        end else begin
`ifdef SPI_SLAVE_PISO_REPEAT_EN
            cur_word = last_word;
`else
            cur_word = '1;
`endif
            exp_ur++;
        end
    endfunction

    function automatic void push_bit(input int bi, input logic endn);
        exp_bits.push_back(endn ? cur_word[W-1-bi] : cur_word[bi]);
    endfunction

    task automatic wr(input logic [W-1:0] d);
        int n;
        @(negedge clk);
        TxData  = d;
        TxValid = 1'b1;
        n = 0;
        while (!TxReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!TxReady) begin
            chk("write_timeout", 0, 1);
            TxValid = 1'b0;
        end else begin
            @(posedge clk);
            mbuf.push_back(d);
            @(negedge clk);
            TxValid = 1'b0;
            chk("txready_fall_after_accept", 32'(TxReady), 0);
        end
    endtask

    task automatic reset_mid();
        in_xfer = 1'b0;
        rstn    = 1'b0;
        #1;
        chk("rst_miso", 32'(MISO), 0);
        chk("rst_misooe", 32'(MISOOE), 0);
        chk("rst_txready", 32'(TxReady), 1);
        chk("rst_worddone", 32'(WordDone), 0);
        chk("rst_underrun", 32'(Underrun), 0);
        model_reset();
        wait_clk(3);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SCLK = ~SCLK;
            wait_clk(H);
            chk("idle_after_reset_misooe", 32'(MISOOE), 0);
        end
    endtask

    task automatic xfer(input logic cpol, input logic cpha, input logic endn, input int nbits,
                        input int wr_bit, input logic [W-1:0] wr_data, input int rst_at);
        int n;
        CPOL = cpol; CPHA = cpha; Endiannes = endn; SCLK = cpol;
        wait_clk(10);
        start_word();
        CSn = 1'b0;
        in_xfer = 1'b1;
        wait_clk(H);
        chk("txready_after_load", 32'(TxReady), 1);
        for (int b = 0; b < nbits; b++) begin
            int bi;
            bi = b % W;
            if (b == rst_at) begin
                reset_mid();
                break;
            end
            if (b == wr_bit && mbuf.size() == 0) wr(wr_data);
            if (!cpha) push_bit(bi, endn);
            SCLK = ~cpol;
            if (!cpha && bi == W-1) begin exp_wd++; start_word(); end
            wait_clk(H);
            if (cpha) push_bit(bi, endn);
            SCLK = cpol;
            if (cpha && bi == W-1) begin exp_wd++; start_word(); end
            wait_clk(H);
        end
        CSn = 1'b1;
        n = 0;
        while (MISOOE && n < SS + 2) begin
            @(negedge clk);
            n++;
        end
        chk("misooe_fall_after_csn_rise", 32'(MISOOE), 0);
        in_xfer = 1'b0;
        wait_clk(6);
    endtask

    always @(SCLK) begin
        if (in_xfer && !CSn) begin
            mon_lead = (SCLK != CPOL);
            if (CPHA ? !mon_lead : mon_lead) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    failures++;
                    $display("FAIL miso_bit: sample edge with no expected bit, got %0b", MISO);
                end else begin
                    mon_exp = exp_bits.pop_front();
                    if (MISO !== mon_exp) begin
                        failures++;
                        $display("FAIL miso_bit: got %0b expected %0b", MISO, mon_exp);
                    end
                end
                chk("misooe_during_xfer", 32'(MISOOE), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (WordDone) begin
                checks++;
                if (exp_wd == 0) begin
                    failures++;
                    $display("FAIL word_done_pulse: got 1 expected 0");
                end else exp_wd--;
            end
            if (Underrun) begin
                checks++;
                if (exp_ur == 0) begin
                    failures++;
                    $display("FAIL underrun_pulse: got 1 expected 0");
                end else exp_ur--;
            end
        end
    end

    initial begin
        rstn = 1'b1; CSn = 1'b1; SCLK = 1'b0; CPOL = 1'b0; CPHA = 1'b0; Endiannes = 1'b0;
        TxValid = 1'b0; TxData = '0; in_xfer = 1'b0;
        model_reset();
        #3 rstn = 1'b0;
        wait_clk(3);
        chk("reset_miso", 32'(MISO), 0);
        chk("reset_misooe", 32'(MISOOE), 0);
        chk("reset_txready", 32'(TxReady), 1);
        chk("reset_worddone", 32'(WordDone), 0);
        chk("reset_underrun", 32'(Underrun), 0);
        rstn = 1'b1;
        wait_clk(5);

        // mode 0, LSB first, 0xA5
        wr(8'hA5);
        xfer(1'b0, 1'b0, 1'b0, 8, -1, 8'h00, -1);
        // mode 3, MSB first, 0x3C then 0xC3 written mid-word
        wr(8'h3C);
        xfer(1'b1, 1'b1, 1'b1, 16, 3, 8'hC3, -1);
        // mode 1: a real word, then an empty-buffer selection (fill or repeat)
        wr(8'h5A);
        xfer(1'b0, 1'b1, 1'b0, 8, -1, 8'h00, -1);
        xfer(1'b0, 1'b1, 1'b0, 8, -1, 8'h00, -1);
        // mode 2: abort after 3 bits, the buffered word goes out next time
        wr(8'hF0);
        xfer(1'b1, 1'b0, 1'b1, 3, 1, 8'h96, -1);
        xfer(1'b1, 1'b0, 1'b1, 8, -1, 8'h00, -1);
        // reset mid-word with CSn held low, then a fresh selection
        wr(8'h77);
        xfer(1'b0, 1'b0, 1'b1, 8, -1, 8'h00, 4);
        xfer(1'b0, 1'b0, 1'b0, 8, -1, 8'h00, -1);

        for (int t = 0; t < 12; t++) begin
            logic [W-1:0] d;
            int nb, wb;
            if (mbuf.size() == 0 && ($urandom % 2) == 1) begin
                d = W'($urandom);
                wr(d);
            end
            nb = $urandom_range(1, 3 * W);
            wb = (($urandom % 3) == 0) ? -1 : $urandom_range(0, nb - 1);
            d  = W'($urandom);
            xfer(1'($urandom), 1'($urandom), 1'($urandom), nb, wb, d, -1);
        end

        wait_clk(10);
        chk("leftover_expected_bits", exp_bits.size(), 0);
        chk("missing_worddone_pulses", exp_wd, 0);
        chk("missing_underrun_pulses", exp_ur, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
